// File: rtl/bcd_stopwatch_counter_if.sv
// Control and display bundle between the debounced button logic and the per-digit decoders.
// master drives the control pulses and load value; slave is the counter that returns the display.
interface bcd_stopwatch_counter_if #(
    parameter int NDIG = 4
);
    logic              start;
    logic              stop;
    logic              clear;
    logic              load;
    logic [4*NDIG-1:0] load_val;
    logic              dir;
    logic [4*NDIG-1:0] digits;
    logic              running;
    logic              tick_o;
    logic              wrap;

    modport master (
        output start, stop, clear, load, load_val, dir,
        input  digits, running, tick_o, wrap
    );

    modport slave (
        input  start, stop, clear, load, load_val, dir,
        output digits, running, tick_o, wrap
    );
endinterface

// File: rtl/bcd_stopwatch_counter.sv
// Purpose: NDIG-digit BCD up/down stopwatch with start/stop/clear/load; leading-zero blanking under BCD_STOPWATCH_BLANK_EN.
// Latency: controls and ticks take effect on the next clock edge; blanking is combinational from the registered count.
// Backpressure: none; control pulses are single-cycle and always accepted by priority clear > load > stop > start.
module bcd_stopwatch_counter #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 100,
    parameter int NDIG    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    bcd_stopwatch_counter_if.slave bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int W   = 4 * NDIG;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSED
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [W-1:0]  count_q, count_d;
    logic          tick_q,  tick_d;
    logic          wrap_q,  wrap_d;

    logic [W-1:0]  load_clamped;
    logic [W-1:0]  count_inc;
    logic [W-1:0]  count_dec;
    logic          inc_carry;
    logic          dec_borrow;
    logic [W-1:0]  digits_disp;

    // Out-of-range nibbles are clamped so the stored count stays valid BCD.
    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (bus.load_val[4*i +: 4] > 4'd9) begin
                load_clamped[4*i +: 4] = 4'd9;
            end else begin
                load_clamped[4*i +: 4] = bus.load_val[4*i +: 4];
            end
        end
    end

    always_comb begin
        logic cy;
        count_inc = count_q;
        cy        = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (cy) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    cy                  = 1'b0;
                end
            end
        end
        inc_carry = cy;
    end

    always_comb begin
        logic bw;
        count_dec = count_q;
        bw        = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (bw) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    count_dec[4*i +: 4] = 4'd9;
                end else begin
                    count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    bw                  = 1'b0;
                end
            end
        end
        dec_borrow = bw;
    end

    // A stop pulse claims priority even when it is ignored, so it also masks a simultaneous start.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (bus.clear) begin
            state_d = ST_IDLE;
            presc_d = '0;
            count_d = '0;
        end else if (bus.load) begin
            count_d = load_clamped;
            presc_d = '0;
            if (state_q == ST_IDLE) begin
                state_d = ST_PAUSED;
            end
        end else if (bus.stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSED;
            end
        end else if (bus.start && (state_q != ST_RUN)) begin
            state_d = ST_RUN;
        end else if (state_q == ST_RUN) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
                count_d = bus.dir ? count_dec  : count_inc;
                wrap_d  = bus.dir ? dec_borrow : inc_carry;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef BCD_STOPWATCH_BLANK_EN
    // A digit blanks only while it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        logic lead;
        digits_disp = count_q;
        lead        = 1'b1;
        for (int i = NDIG - 1; i >= 1; i--) begin
            if (lead && (count_q[4*i +: 4] == 4'd0)) begin
                digits_disp[4*i +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
    end
`else
    assign digits_disp = count_q;
`endif

    assign bus.digits  = digits_disp;
    assign bus.running = (state_q == ST_RUN);
    assign bus.tick_o  = tick_q;
    assign bus.wrap    = wrap_q;

    for (genvar g = 0; g < NDIG; g++) begin : g_bcd_chk
        a_valid_bcd: assert property (@(posedge clk) disable iff (rst) count_q[4*g +: 4] <= 4'd9);
    end
endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Directed bench for bcd_stopwatch_counter with a decimal-integer reference model checked every cycle.
module tb_bcd_stopwatch_counter;
    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int NDIG    = 4;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int MAXV    = 9999;
`ifdef BCD_STOPWATCH_BLANK_EN
    localparam logic [15:0] ZERO_DISP = 16'hFFF0;
    localparam logic [15:0] D0042     = 16'hFF42;
`else
    localparam logic [15:0] ZERO_DISP = 16'h0000;
    localparam logic [15:0] D0042     = 16'h0042;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    bcd_stopwatch_counter_if #(.NDIG(NDIG)) bus ();

    bcd_stopwatch_counter #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ),
        .NDIG   (NDIG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: count kept as a plain decimal integer, state as 0=idle 1=run 2=paused.
    int m_cnt = 0;
    int m_ph  = 0;
    int m_st  = 0;
    bit m_tk  = 1'b0;
    bit m_wr  = 1'b0;

    function automatic int clamp_val(input logic [15:0] v);
        int r;
        int n;
        r = 0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            n = int'(v[4*i +: 4]);
            if (n > 9) n = 9;
            r = r * 10 + n;
        end
        return r;
    endfunction

    function automatic logic [15:0] disp(input int v);
        logic [15:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef BCD_STOPWATCH_BLANK_EN
        for (int i = 1; i < NDIG; i++) begin
            if (v < 10 ** i) r[4*i +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    always @(posedge clk) begin
        m_tk = 1'b0;
        m_wr = 1'b0;
        if (rst) begin
            m_cnt = 0; m_ph = 0; m_st = 0;
        end else if (bus.clear) begin
            m_cnt = 0; m_ph = 0; m_st = 0;
        end else if (bus.load) begin
            m_cnt = clamp_val(bus.load_val);
            m_ph  = 0;
            if (m_st == 0) m_st = 2;
        end else if (bus.stop) begin
            if (m_st == 1) m_st = 2;
        end else if (bus.start && m_st != 1) begin
            m_st = 1;
        end else if (m_st == 1) begin
            if (m_ph == DIV - 1) begin
                m_ph = 0;
                m_tk = 1'b1;
                if (bus.dir) begin
                    if (m_cnt == 0) begin m_cnt = MAXV; m_wr = 1'b1; end
                    else m_cnt = m_cnt - 1;
                end else begin
                    if (m_cnt == MAXV) begin m_cnt = 0; m_wr = 1'b1; end
                    else m_cnt = m_cnt + 1;
                end
            end else begin
                m_ph = m_ph + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("digits",  32'(bus.digits),  32'(disp(m_cnt)));
            chk("running", 32'(bus.running), 32'(m_st == 1));
            chk("tick_o",  32'(bus.tick_o),  32'(m_tk));
            chk("wrap",    32'(bus.wrap),    32'(m_wr));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ctrl(input bit s_start, input bit s_stop, input bit s_clear,
                        input bit s_load, input logic [15:0] v);
        bus.start    = s_start;
        bus.stop     = s_stop;
        bus.clear    = s_clear;
        bus.load     = s_load;
        bus.load_val = v;
        step(1);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.clear = 1'b0;
        bus.load  = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0; bus.load = 1'b0;
        bus.load_val = '0; bus.dir = 1'b0;
        step(2);
        chk_en = 1'b1;
        chk("rst_digits",  32'(bus.digits), 32'(ZERO_DISP));
        chk("rst_running", 32'(bus.running), 32'd0);
        chk("rst_tick",    32'(bus.tick_o), 32'd0);
        rst = 1'b0;
        step(1);

        // Count up from zero: ticks land 10 and 20 edges after start.
        ctrl(1, 0, 0, 0, 16'h0);
        step(9);
        chk("up_pre_tick", 32'(bus.tick_o), 32'd0);
        step(1);
        chk("up_tick1",    32'(bus.tick_o), 32'd1);
        chk("up_cnt1",     32'(m_cnt), 32'd1);
        step(10);
        chk("up_tick2",    32'(bus.tick_o), 32'd1);
        step(5);
        chk("up_cnt25",    32'(m_cnt), 32'd2);
        chk("up_running",  32'(bus.running), 32'd1);

        // Up rollover 9998 -> 9999 -> 0000.
        ctrl(0, 0, 1, 0, 16'h0);
        ctrl(0, 0, 0, 1, 16'h9998);
        chk("load_9998", 32'(bus.digits), 32'h9998);
        ctrl(1, 0, 0, 0, 16'h0);
        step(10);
        chk("roll_9999",   32'(bus.digits), 32'h9999);
        chk("roll_nowrap", 32'(bus.wrap), 32'd0);
        step(10);
        chk("roll_0000",   32'(bus.digits), 32'(ZERO_DISP));
        chk("roll_wrap",   32'(bus.wrap), 32'd1);
        chk("roll_tick",   32'(bus.tick_o), 32'd1);

        // Down underflow, then a clamped load while running.
        ctrl(0, 0, 1, 0, 16'h0);
        bus.dir = 1'b1;
        ctrl(1, 0, 0, 0, 16'h0);
        step(10);
        chk("dn_9999", 32'(bus.digits), 32'h9999);
        chk("dn_wrap", 32'(bus.wrap), 32'd1);
        ctrl(0, 0, 0, 1, 16'h1A0C);
        chk("clamp_1909", 32'(bus.digits), 32'h1909);
        chk("clamp_run",  32'(bus.running), 32'd1);

        // Pause mid-period keeps the partial prescaler count.
        bus.dir = 1'b0;
        ctrl(0, 0, 1, 0, 16'h0);
        ctrl(1, 0, 0, 0, 16'h0);
        step(50);
        chk("pz_cnt5", 32'(m_cnt), 32'd5);
        step(4);
        ctrl(0, 1, 0, 0, 16'h0);
        step(50);
        chk("pz_hold",  32'(m_cnt), 32'd5);
        chk("pz_stop",  32'(bus.running), 32'd0);
        ctrl(1, 0, 0, 0, 16'h0);
        step(5);
        chk("pz_notick", 32'(bus.tick_o), 32'd0);
        step(1);
        chk("pz_tick",   32'(bus.tick_o), 32'd1);
        chk("pz_cnt6",   32'(m_cnt), 32'd6);

        // Simultaneous stop/clear/start, then reset mid-count.
        ctrl(1, 1, 1, 0, 16'h0);
        chk("multi_run",    32'(bus.running), 32'd0);
        chk("multi_digits", 32'(bus.digits), 32'(ZERO_DISP));
        ctrl(0, 0, 0, 1, 16'h0317);
        ctrl(1, 0, 0, 0, 16'h0);
        step(3);
        rst = 1'b1;
        step(1);
        chk("rst_mid_digits", 32'(bus.digits), 32'(ZERO_DISP));
        chk("rst_mid_run",    32'(bus.running), 32'd0);
        rst = 1'b0;
        step(1);

        // Leading-zero display and a borrow across two digits.
        ctrl(0, 0, 0, 1, 16'h0042);
        chk("disp_0042", 32'(bus.digits), 32'(D0042));
        ctrl(0, 0, 0, 1, 16'h0000);
        chk("disp_0000", 32'(bus.digits), 32'(ZERO_DISP));
        ctrl(0, 0, 0, 1, 16'h1000);
        chk("disp_1000", 32'(bus.digits), 32'h1000);
        ctrl(0, 0, 0, 1, 16'h0100);
        bus.dir = 1'b1;
        ctrl(1, 0, 0, 0, 16'h0);
        step(10);
        chk("borrow_99", 32'(m_cnt), 32'd99);
        step(3);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
